command_frame_receiver: RTL and testbench

Front end of the image processor's UART link. It deserialises the 8N1 `rx` line into bytes, hunts for the 0xCD 0xBA frame header, and decodes and validates the two-byte command. It then streams the encoded-image payload bytes to the JPEG decoder until the line goes idle. It feeds the filter controller (command code) and the decoder (payload bytes).

---
 rtl/command_frame_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_command_frame_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/command_frame_receiver.sv
// UART 8N1 command-frame front end: byte deserialiser, 0xCD 0xBA header hunt, command decode, payload stream.
// Optional stop-bit checking with frame_error is enabled by defining CMD_RX_STOP_CHECK_EN.
module command_frame_receiver #(
  parameter int CLK_FREQ  = 10_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int IDLE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       cmd_error,
  output logic       frame_error,
  output logic       payload_valid,
  output logic [7:0] payload_data,
  output logic       payload_done,
  output logic       busy
);

  localparam int T        = CLK_FREQ / BAUD_RATE;
  localparam int TW       = $clog2(T + 1);
  localparam int IDLE_LIM = IDLE_BITS * T;
  localparam int IW       = $clog2(IDLE_LIM + 1);

  localparam logic [TW-1:0] HALF_LD  = TW'(T / 2 - 1);
  localparam logic [TW-1:0] BIT_LD   = TW'(T - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIM);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {HDR0, HDR1, CMD0, CMD1, PAYLOAD} fr_state_e;

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            rx_fall, timer_zero, stop_sample, byte_strobe;

  fr_state_e       fr_state_q, fr_state_d;
  logic [3:0]      pend_q, pend_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            idle_hit, cmd_ok;

  logic            cmd_valid_q, cmd_valid_d;
  logic [3:0]      cmd_code_q, cmd_code_d;
  logic            cmd_error_q, cmd_error_d;
  logic            payload_valid_q, payload_valid_d;
  logic [7:0]      payload_data_q, payload_data_d;
  logic            payload_done_q, payload_done_d;

  assign rx_fall     = prev_q & ~sync2_q;
  assign timer_zero  = (timer_q == '0);
  assign stop_sample = (rx_state_q == RX_STOP) && timer_zero;

  // ---------------- byte receiver ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    timer_d    = timer_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          timer_d    = HALF_LD;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (!timer_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (sync2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          timer_d    = BIT_LD;
          bitcnt_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!timer_zero) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shreg_d  = {sync2_q, shreg_q[7:1]};
          timer_d  = BIT_LD;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!timer_zero) timer_d = timer_q - 1'b1;
        else             rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef CMD_RX_STOP_CHECK_EN
  logic frame_error_q;

  assign byte_strobe = stop_sample & sync2_q;
  assign frame_error = frame_error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_error_q <= 1'b0;
    else      frame_error_q <= stop_sample & ~sync2_q;
  end
`else
  assign byte_strobe = stop_sample;
  assign frame_error = 1'b0;
`endif

  // ---------------- idle timeout ----------------
  assign idle_hit = (fr_state_q != HDR0) && (idle_q == IDLE_MAX);

  always_comb begin
    idle_d = idle_q;
    if (byte_strobe || rx_fall)  idle_d = '0;
    else if (fr_state_q != HDR0) idle_d = idle_hit ? '0 : idle_q + 1'b1;
  end

  // ---------------- frame FSM ----------------
  assign cmd_ok = (shreg_q[3:0] == 4'h0) && (shreg_q[7:4] >= 4'd1) && (shreg_q[7:4] <= 4'd6);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fr_state_q      <= HDR0;
      pend_q          <= '0;
      idle_q          <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_code_q      <= '0;
      cmd_error_q     <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_data_q  <= '0;
      payload_done_q  <= 1'b0;
    end else begin
      fr_state_q      <= fr_state_d;
      pend_q          <= pend_d;
      idle_q          <= idle_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_code_q      <= cmd_code_d;
      cmd_error_q     <= cmd_error_d;
      payload_valid_q <= payload_valid_d;
      payload_data_q  <= payload_data_d;
      payload_done_q  <= payload_done_d;
    end
  end

  // A byte arriving in the same cycle as the idle limit takes priority.
  always_comb begin
    fr_state_d = fr_state_q;
    pend_d     = pend_q;
    if (byte_strobe) begin
      case (fr_state_q)
        HDR0:    if (shreg_q == 8'hCD) fr_state_d = HDR1;
        HDR1: begin
          if (shreg_q == 8'hBA)      fr_state_d = CMD0;
          else if (shreg_q != 8'hCD) fr_state_d = HDR0;
        end
        CMD0: begin
          if (cmd_ok) begin
            pend_d     = shreg_q[7:4];
            fr_state_d = CMD1;
          end else begin
            fr_state_d = HDR0;
          end
        end
        CMD1:    fr_state_d = (shreg_q == 8'hA0) ? PAYLOAD : HDR0;
        PAYLOAD: fr_state_d = PAYLOAD;
        default: fr_state_d = HDR0;
      endcase
    end else if (idle_hit) begin
      fr_state_d = HDR0;
    end
  end

  always_comb begin
    cmd_valid_d     = byte_strobe && (fr_state_q == CMD1) && (shreg_q == 8'hA0);
    cmd_error_d     = byte_strobe && (((fr_state_q == CMD0) && !cmd_ok) ||
                                      ((fr_state_q == CMD1) && (shreg_q != 8'hA0)));
    payload_valid_d = byte_strobe && (fr_state_q == PAYLOAD);
    payload_data_d  = payload_valid_d ? shreg_q : payload_data_q;
    cmd_code_d      = cmd_valid_d ? pend_q : cmd_code_q;
    payload_done_d  = !byte_strobe && idle_hit && (fr_state_q == PAYLOAD);
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_code      = cmd_code_q;
  assign cmd_error     = cmd_error_q;
  assign payload_valid = payload_valid_q;
  assign payload_data  = payload_data_q;
  assign payload_done  = payload_done_q;
  assign busy          = (fr_state_q != HDR0);

endmodule

// File: tb/tb_command_frame_receiver.sv
// Directed bench for command_frame_receiver at default parameters (T = 86 clocks per bit).
module tb_command_frame_receiver;

  localparam int T    = 86;
  localparam int IDLE = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       cmd_valid, cmd_error, frame_error, payload_valid, payload_done, busy;
  logic [3:0] cmd_code;
  logic [7:0] payload_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;

  int n_cmd = 0, n_cerr = 0, n_ferr = 0, n_pv = 0, n_pdone = 0, cmd_cyc = 0;
  logic [7:0] pay_q[$];

  int s_cmd, s_cerr, s_ferr, s_pv, s_pdone;

  command_frame_receiver dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_error     (cmd_error),
    .frame_error   (frame_error),
    .payload_valid (payload_valid),
    .payload_data  (payload_data),
    .payload_done  (payload_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cmd   <= n_cmd + 1;
      cmd_cyc <= cyc;
    end
    if (cmd_error)    n_cerr  <= n_cerr + 1;
    if (frame_error)  n_ferr  <= n_ferr + 1;
    if (payload_done) n_pdone <= n_pdone + 1;
    if (payload_valid) begin
      n_pv <= n_pv + 1;
      pay_q.push_back(payload_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_cmd = n_cmd; s_cerr = n_cerr; s_ferr = n_ferr; s_pv = n_pv; s_pdone = n_pdone;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (T) @(negedge clk);
    end
    rx = stop_bit;
    repeat (T) @(negedge clk);
    rx = 1'b1;
    repeat (T) @(negedge clk);
  endtask

  initial begin
    int lat;
    int base;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_payload_valid", payload_valid, 0);
    check("rst_payload_data", payload_data, 0);
    check("rst_payload_done", payload_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // command 5
    snap();
    send_byte(8'hCD, 1'b1);
    check("hdr0_busy", busy, 1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h50, 1'b1);
    send_byte(8'hA0, 1'b1);
    check("cmd5_count", n_cmd - s_cmd, 1);
    check("cmd5_code", cmd_code, 5);
    check("cmd5_no_error", n_cerr - s_cerr, 0);
    check("cmd5_busy", busy, 1);
    lat = cmd_cyc - fall_cyc;
    check("cmd_latency_in_range", (lat >= 819 && lat <= 821), 1);

    // payload 0x12 0xCD 0xFF, then idle timeout
    base = pay_q.size();
    snap();
    send_byte(8'h12, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("pay_count", n_pv - s_pv, 3);
    check("pay_byte0", pay_q[base], 8'h12);
    check("pay_byte1", pay_q[base + 1], 8'hCD);
    check("pay_byte2", pay_q[base + 2], 8'hFF);
    check("pay_data_held", payload_data, 8'hFF);
    check("pay_no_cmd", n_cmd - s_cmd, 0);
    repeat (18 * T) @(negedge clk);
    check("pay_busy_before_timeout", busy, 1);
    check("pay_no_early_done", n_pdone - s_pdone, 0);
    repeat (3 * T) @(negedge clk);
    check("pay_done_count", n_pdone - s_pdone, 1);
    check("pay_busy_after_timeout", busy, 0);

    // repeated header byte resynchronises
    snap();
    send_byte(8'hCD, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'hA0, 1'b1);
    check("resync_cmd_count", n_cmd - s_cmd, 1);
    check("resync_cmd_code", cmd_code, 1);
    repeat ((IDLE + 1) * T) @(negedge clk);
    check("resync_timeout_done", n_pdone - s_pdone, 1);
    check("resync_idle_busy", busy, 0);

    // bad command nibble
    snap();
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h70, 1'b1);
    check("bad70_error", n_cerr - s_cerr, 1);
    check("bad70_busy", busy, 0);

    // bad trailer byte
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'hB0, 1'b1);
    check("badB0_error", n_cerr - s_cerr, 2);
    check("bad_no_cmd", n_cmd - s_cmd, 0);
    check("bad_code_held", cmd_code, 1);
    check("bad_busy", busy, 0);

    // stop bit low inside payload
    snap();
    base = pay_q.size();
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'hA0, 1'b1);
    check("cmd3_code", cmd_code, 3);
    send_byte(8'h5A, 1'b0);
`ifdef CMD_RX_STOP_CHECK_EN
    check("stoplow_frame_error", n_ferr - s_ferr, 1);
    check("stoplow_no_byte", n_pv - s_pv, 0);
`else
    check("stoplow_no_frame_error", n_ferr - s_ferr, 0);
    check("stoplow_byte_count", n_pv - s_pv, 1);
    check("stoplow_byte_value", pay_q[base], 8'h5A);
`endif
    check("stoplow_busy", busy, 1);
    repeat ((IDLE + 1) * T) @(negedge clk);
    check("stoplow_idle_busy", busy, 0);

    // short low glitch is a false start
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (26) @(negedge clk);
    rx = 1'b1;
    repeat (12 * T) @(negedge clk);
    check("glitch_no_cmd_error", n_cerr - s_cerr, 0);
    check("glitch_no_frame_error", n_ferr - s_ferr, 0);
    check("glitch_busy", busy, 0);

    // reset in the middle of a payload byte
    send_byte(8'hCD, 1'b1);
    send_byte(8'hBA, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'hA0, 1'b1);
    check("cmd4_code", cmd_code, 4);
    check("cmd4_count", n_cmd - s_cmd, 1);
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * T) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_cmd_code", cmd_code, 0);
    check("mid_rst_payload_data", payload_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_payload_valid", payload_valid, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat ((IDLE + 2) * T) @(negedge clk);
    check("post_rst_no_payload", n_pv - s_pv, 0);
    check("post_rst_no_done", n_pdone - s_pdone, 0);
    check("post_rst_no_cmd", n_cmd - s_cmd, 0);
    check("post_rst_no_error", (n_cerr - s_cerr) + (n_ferr - s_ferr), 0);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
